// File: rtl/hc595_pkg.sv
// hc595_pkg: shared types and defaults for the 74HC595 serial display driver.
//   state_e      - controller states (IDLE, SHIFT, LATCH)
//   HC595_WIDTH  - default frame width (segment byte + select byte)
//   HC595_SCLK_DIV - default clk cycles per sh_cp half-period
//   cnt_w()      - minimum counter width able to hold 0..n-1 (at least 1 bit)
package hc595_pkg;

  localparam int unsigned HC595_WIDTH    = 16;
  localparam int unsigned HC595_SCLK_DIV = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hc595_sclk_gen.sv
// hc595_sclk_gen: half-period tick generator for the 74HC595 shift clock.
//   clk    - clock
//   rst    - asynchronous active-high reset
//   clr    - synchronous clear; holds the divider at zero (asserted in IDLE)
//   tick_c - combinational tick, high on the last cycle of each half-period
module hc595_sclk_gen
  import hc595_pkg::*;
#(
  parameter int unsigned SCLK_DIV = HC595_SCLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CW   = cnt_w(SCLK_DIV);
  localparam logic [CW-1:0] TERM = CW'(SCLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick_c = (cnt == TERM);

  // Counts 0..SCLK_DIV-1 and wraps on the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hc595_ctrl.sv
// hc595_ctrl: serialises one WIDTH-bit frame into two cascaded 74HC595s,
// MSB first, then pulses the storage latch.
//   clk   - clock (rising edge)
//   rst   - asynchronous active-high reset
//   start - frame request, sampled only in IDLE
//   data  - frame {seg, sel}, captured on the accept edge
//   busy  - frame in progress
//   done  - one-cycle pulse when the frame has been latched
//   ds    - serial data to DS
//   sh_cp - shift clock to SH_CP
//   st_cp - storage clock to ST_CP
//   oe_n  - output enable to OE (only with HC595_OE_EN defined); held high
//           until the first latched frame so power-up garbage stays blanked
module hc595_ctrl
  import hc595_pkg::*;
#(
  parameter int unsigned WIDTH    = HC595_WIDTH,
  parameter int unsigned SCLK_DIV = HC595_SCLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             ds,
  output logic             sh_cp,
`ifdef HC595_OE_EN
  output logic             oe_n,
`endif
  output logic             st_cp
);

  localparam int unsigned BW = cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BW-1:0]    bit_cnt;
  logic             tick_c;

  assign shreg_nxt = shreg << 1;

  // Divider is parked at zero in IDLE so every frame starts phase-aligned.
  hc595_sclk_gen #(
    .SCLK_DIV(SCLK_DIV)
  ) u_sclk_gen (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == IDLE),
    .tick_c(tick_c)
  );

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ds      <= 1'b0;
      sh_cp   <= 1'b0;
      st_cp   <= 1'b0;
`ifdef HC595_OE_EN
      oe_n    <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SHIFT;
            shreg   <= data;
            bit_cnt <= '0;
            busy    <= 1'b1;
            sh_cp   <= 1'b0;
            ds      <= data[WIDTH-1];
          end
        end
        SHIFT: begin
          if (tick_c) begin
            if (!sh_cp) begin
              sh_cp <= 1'b1;
            end else begin
              // Falling sh_cp edge: the only place ds is allowed to move.
              sh_cp <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                state   <= LATCH;
                bit_cnt <= '0;
                ds      <= 1'b0;
                st_cp   <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
                shreg   <= shreg_nxt;
                ds      <= shreg_nxt[WIDTH-1];
              end
            end
          end
        end
        LATCH: begin
          if (tick_c) begin
            state <= IDLE;
            st_cp <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef HC595_OE_EN
            oe_n  <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc595_ctrl.sv
// tb_hc595_ctrl: directed + randomized bench for hc595_ctrl (WIDTH=16,
// SCLK_DIV=4). Expected outputs come from a cycle-index model of the frame
// timeline. Define HC595_OE_EN to also check oe_n.
module tb_hc595_ctrl;

  localparam int unsigned W    = 16;
  localparam int unsigned D    = 4;
  localparam int          LAST = 2 * D * W + D;  // done cycle index

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] data;
  logic         busy;
  logic         done;
  logic         ds;
  logic         sh_cp;
  logic         st_cp;
`ifdef HC595_OE_EN
  logic         oe_n;
`endif

  int checks   = 0;
  int errs     = 0;
  int st_pulses = 0;
  bit oe_exp   = 1'b1;

  hc595_ctrl #(
    .WIDTH   (W),
    .SCLK_DIV(D)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (data),
    .busy (busy),
    .done (done),
    .ds   (ds),
    .sh_cp(sh_cp),
`ifdef HC595_OE_EN
    .oe_n (oe_n),
`endif
    .st_cp(st_cp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge st_cp) st_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {busy, done, ds, sh_cp, st_cp} n cycles after the accept edge.
  function automatic logic [4:0] exp_out(input logic [W-1:0] d, input int n);
    int b;
    int ph;
    if (n < 2 * D * W) begin
      b  = n / (2 * D);
      ph = n % (2 * D);
      return {1'b1, 1'b0, d[W-1-b], (ph >= D), 1'b0};
    end else if (n < LAST) begin
      return 5'b10001;
    end
    return 5'b01000;
  endfunction

  function automatic logic [4:0] outs();
    return {busy, done, ds, sh_cp, st_cp};
  endfunction

  task automatic chk_oe(input string tag);
`ifdef HC595_OE_EN
    chk(tag, 32'(oe_n), 32'(oe_exp));
`else
    if (tag.len() == 0) $display("");
`endif
  endtask

  // Runs one frame from its accept edge through its done cycle. start is
  // re-asserted with data=FFFF on edge 'poke'; keep holds start high.
  task automatic run_frame(input logic [W-1:0] d, input int poke, input bit keep);
    logic [W-1:0] got;
    int rises;
    int sth;
    int dones;
    logic prev_sh;
    got = '0; rises = 0; sth = 0; dones = 0; prev_sh = 1'b0;
    data  = d;
    start = 1'b1;
    for (int n = 0; n <= LAST; n++) begin
      @(posedge clk); #1;
      chk("cycle", 32'(outs()), 32'(exp_out(d, n)));
      if (sh_cp && !prev_sh) begin
        got = {got[W-2:0], ds};
        rises++;
      end
      prev_sh = sh_cp;
      sth   += int'(st_cp);
      dones += int'(done);
      if (n == LAST) oe_exp = 1'b0;
      chk_oe("oe_n_frame");
      start = keep || (n + 1 == poke);
      data  = (n + 1 == poke) ? {W{1'b1}} : W'($urandom);
    end
    chk("ds_word", 32'(got), 32'(d));
    chk("sh_rises", 32'(rises), 32'(W));
    chk("st_high", 32'(sth), 32'(D));
    chk("done_cnt", 32'(dones), 32'd1);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      chk("idle", 32'(outs()), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] d;
    int p0;
    rst = 1'b0; start = 1'b0; data = '0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset_async", 32'(outs()), 32'd0);
    chk_oe("oe_n_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(3);

    // Basic frame with a rejected start at edge 10.
    run_frame(16'hC001, 10, 1'b0);
    idle_cycles(2);

    // Back-to-back frames: start held high, including boundary patterns.
    run_frame(W'($urandom), 0, 1'b1);
    run_frame(16'hFFFF, 0, 1'b1);
    run_frame(16'h0000, 0, 1'b1);
    run_frame(W'($urandom), 0, 1'b0);
    idle_cycles(1);

    // Random frames with random gaps.
    for (int k = 0; k < 6; k++) begin
      run_frame(W'($urandom), int'($urandom_range(1, LAST)), 1'b0);
      idle_cycles(int'($urandom_range(1, 5)));
    end

    // Reset in the middle of a frame.
    d = W'($urandom);
    data = d; start = 1'b1;
    for (int n = 0; n <= 50; n++) begin
      @(posedge clk); #1;
      chk("pre_abort", 32'(outs()), 32'(exp_out(d, n)));
      start = 1'b0;
    end
    p0 = st_pulses;
    rst = 1'b1;
    #1;
    chk("abort_async", 32'(outs()), 32'd0);
    oe_exp = 1'b1;
    chk_oe("oe_n_abort");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_hold", 32'(outs()), 32'd0);
    end
    rst = 1'b0;
    idle_cycles(150);
    chk("abort_no_latch", 32'(st_pulses), 32'(p0));
    chk_oe("oe_n_after_abort");

    // Fresh frame after the aborted one.
    run_frame(W'($urandom), 0, 1'b0);
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule

// File: doc/hc595_ctrl.md
HC595_CTRL -- requirements
Module: hc595_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, 16, number of bits per frame (segment byte plus select byte, two cascaded 74HC595), legal 1..64.
REQ-002 SHALL have parameter SCLK_DIV, 4, clk cycles per sh_cp half-period, legal 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  frame request; sampled only in IDLE.
REQ-006 SHALL have port data  input  WIDTH  frame to send, {seg, sel} from the display decoder.
REQ-007 SHALL have port busy  output  1  high while a frame is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-009 SHALL have port ds  output  1  serial data to the first 74HC595 DS pin.
REQ-010 SHALL have port sh_cp  output  1  shift clock to SH_CP.
REQ-011 SHALL have port st_cp  output  1  storage latch clock to ST_CP.

Function
REQ-012 SHALL implement states IDLE, SHIFT, LATCH; IDLE->SHIFT on start, SHIFT->LATCH after the last bit, LATCH->IDLE after SCLK_DIV cycles.
REQ-013 SHALL, at the start-accept edge (edge 0), capture data into a shift register, set busy=1, sh_cp=0 and ds=data[WIDTH-1].
REQ-014 SHALL send MSB first; each bit occupies 2*SCLK_DIV cycles: sh_cp low for SCLK_DIV cycles, then high for SCLK_DIV cycles; ds is stable for the whole bit.
REQ-015 SHALL change ds only on the edge where sh_cp falls, i.e. never while sh_cp is high.
REQ-016 SHALL enter LATCH at edge 2*SCLK_DIV*WIDTH with sh_cp=0 and st_cp=1; st_cp stays high for SCLK_DIV cycles.
REQ-017 SHALL return to IDLE at edge 2*SCLK_DIV*WIDTH+SCLK_DIV with st_cp=0, busy=0, done=1 for exactly one cycle.
REQ-018 SHALL ignore start while busy (no queueing) and ignore data changes after capture.
REQ-019 SHALL accept a new start in the same cycle that done is high; the next frame begins without an idle gap.
REQ-020 SHALL hold ds=0, sh_cp=0, st_cp=0 in IDLE.
REQ-021 SHALL size the bit counter and divider counter to the minimum width for WIDTH and SCLK_DIV; both wrap to 0 on their terminal count, never overflow.

Reset
REQ-022 SHALL, on rst high, immediately force state=IDLE, busy=0, done=0, ds=0, sh_cp=0, st_cp=0, and clear all counters.
REQ-023 SHALL, on reset mid-frame, never issue an st_cp pulse for the aborted frame, so the 74HC595 outputs keep the last latched value.

Configuration
REQ-024 SHALL provide macro HC595_OE_EN; when defined, an extra port oe_n (output, 1 bit, to the 74HC595 OE pin) is present.
REQ-025 SHALL, with HC595_OE_EN defined, drive oe_n=1 from reset until the first completed LATCH, then oe_n=0 until the next reset; this blanks power-up garbage.
REQ-026 SHALL, without HC595_OE_EN, omit the oe_n port entirely; all other behaviour is identical.

Structure
REQ-027 SHALL place the state enum (IDLE, SHIFT, LATCH) and the default WIDTH/SCLK_DIV constants in shared package hc595_pkg.
REQ-028 SHALL implement the divider as one sub-module, hc595_sclk_gen, which produces a half-period tick, is cleared on rst, and is held in reset while in IDLE.

Verification
REQ-029 SHALL cover reset values: rst high -> all outputs 0 (oe_n=1 with HC595_OE_EN) on the same cycle, with no clk edge required.
REQ-030 SHALL cover a basic frame: WIDTH=16, SCLK_DIV=4, data=16'hC001, start pulse -> 16 sh_cp rising edges, sampled ds sequence 1100_0000_0000_0001, st_cp high for 4 cycles, done at edge 132.
REQ-031 SHALL cover busy rejection: start re-asserted at edge 10 with data=16'hFFFF -> frame still sends 16'hC001, exactly one done.
REQ-032 SHALL cover back-to-back frames: start held high continuously -> second frame's edge 0 coincides with the first frame's done cycle, no gap cycles.
REQ-033 SHALL cover reset mid-frame: rst asserted at edge 50 -> zero st_cp pulses, all outputs 0; after release, a fresh start completes normally.
REQ-034 SHALL cover HC595_OE_EN: oe_n=1 through the first frame and drops to 0 on the done cycle; a subsequent reset returns oe_n to 1.
